window_ring_buffer: RTL and testbench

Parametrised N-bank sample window buffer that sits between the audio sample stream and the pitch-shift processor. It generalises the fixed two-window ping-pong scheme to NUM_BANKS windows of configurable width and depth. It adds claim/release ownership of windows, backpressure-free overflow detection and fill-level reporting, so the processor may fall behind by up to NUM_BANKS-1 windows without losing data.

---
 rtl/window_ring_buffer_pkg.sv | 13 +
 rtl/window_ring_buffer_ram.sv | 62 ++++++
 rtl/window_ring_buffer.sv | 166 ++++++++++++++++
 tb/tb_window_ring_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_ring_buffer_pkg.sv
// Shared types and constants for the N-bank sample window buffer.
package window_buf_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        ACTIVE  = 2'd3
    } bank_state_t;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/window_ring_buffer_ram.sv
// Single-clock true dual-port RAM, read-first on both ports, with an optional
// output register stage (HIGH_PERFORMANCE) giving two-cycle read latency.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    localparam int   ADDR_W          = $clog2(RAM_DEPTH)
) (
    input  logic [ADDR_W-1:0]    addra,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic [RAM_WIDTH-1:0] dinb,
    input  logic                 clka,
    input  logic                 wea,
    input  logic                 web,
    input  logic                 ena,
    input  logic                 enb,
    input  logic                 rsta,
    input  logic                 rstb,
    input  logic                 regcea,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] douta,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a_q;
    logic [RAM_WIDTH-1:0] ram_data_b_q;

    // Both ports share one process so reads always observe pre-edge contents.
    always_ff @(posedge clka) begin
        if (ena) begin
            ram_data_a_q <= mem_q[addra];
            if (wea) mem_q[addra] <= dina;
        end
        if (enb) begin
            ram_data_b_q <= mem_q[addrb];
            if (web) mem_q[addrb] <= dinb;
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
            assign douta = ram_data_a_q;
            assign doutb = ram_data_b_q;
        end else begin : g_out_reg
            logic [RAM_WIDTH-1:0] douta_q;
            logic [RAM_WIDTH-1:0] doutb_q;

            always_ff @(posedge clka) begin
                if (rsta)        douta_q <= '0;
                else if (regcea) douta_q <= ram_data_a_q;
                if (rstb)        doutb_q <= '0;
                else if (regceb) doutb_q <= ram_data_b_q;
            end

            assign douta = douta_q;
            assign doutb = doutb_q;
        end
    endgenerate

endmodule

// File: rtl/window_ring_buffer.sv
// N-bank sample window buffer: the writer fills banks in ring order, the processor
// claims the oldest FULL bank, reads it through a 2-cycle RAM port and releases it.
module window_ring_buffer
    import window_buf_pkg::*;
#(
    parameter int  SAMPLE_WIDTH = 16,
    parameter int  WINDOW_SIZE  = 2048,
    parameter int  NUM_BANKS    = 3,
    localparam int WIN_BITS     = $clog2(WINDOW_SIZE),
    localparam int BANK_BITS    = $clog2(NUM_BANKS)
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    output logic                    win_avail_out,
    output logic [BANK_BITS-1:0]    win_bank_out,
    input  logic                    win_claim_in,
    input  logic                    win_release_in,
    input  logic                    rd_en_in,
    input  logic [WIN_BITS-1:0]     rd_addr_in,
    output logic [SAMPLE_WIDTH-1:0] rd_data_out,
    output logic                    rd_valid_out,
    output logic [BANK_BITS:0]      fill_level_out,
    output logic                    overflow_out,
    output logic [DROP_CNT_W-1:0]   dropped_count_out
);

    bank_state_t             state_q [NUM_BANKS];
    bank_state_t             state_d [NUM_BANKS];
    logic [BANK_BITS-1:0]    wr_bank_q, wr_bank_d;
    logic [WIN_BITS-1:0]     wr_addr_q, wr_addr_d;
    logic [BANK_BITS-1:0]    rd_bank_q, rd_bank_d;
    logic [BANK_BITS-1:0]    act_bank_q, act_bank_d;
    logic                    act_vld_q, act_vld_d;
    logic                    avail_q, avail_d;
    logic [BANK_BITS:0]      fill_q, fill_d;
    logic                    overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [1:0]              rd_vld_q;

    logic                    wr_fire;
    logic                    drop;
    logic                    claim_ok;
    logic                    rel_ok;
    logic                    rd_fire;
    logic [SAMPLE_WIDTH-1:0] ram_douta_unused;
    logic [SAMPLE_WIDTH-1:0] ram_doutb;

    function automatic logic [BANK_BITS-1:0] bank_inc(input logic [BANK_BITS-1:0] b);
        return (b == BANK_BITS'(NUM_BANKS - 1)) ? '0 : b + BANK_BITS'(1);
    endfunction

    assign wr_fire  = sample_valid_in && (state_q[wr_bank_q] == FILLING);
    assign drop     = sample_valid_in && !wr_fire;
    assign claim_ok = win_claim_in && avail_q && !act_vld_q;
    assign rel_ok   = win_release_in && act_vld_q;
    assign rd_fire  = rd_en_in && act_vld_q;

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        rd_bank_d  = rd_bank_q;
        act_bank_d = act_bank_q;
        act_vld_d  = act_vld_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        fill_d     = '0;
        avail_d    = 1'b0;

        if (claim_ok) begin
            state_d[rd_bank_q] = ACTIVE;
            act_bank_d         = rd_bank_q;
            act_vld_d          = 1'b1;
            rd_bank_d          = bank_inc(rd_bank_q);
        end
        if (rel_ok) begin
            state_d[act_bank_q] = FREE;
            act_vld_d           = 1'b0;
        end

        if (wr_fire) begin
            if (wr_addr_q == WIN_BITS'(WINDOW_SIZE - 1)) begin
                state_d[wr_bank_q] = FULL;
                wr_addr_d          = '0;
                wr_bank_d          = bank_inc(wr_bank_q);
            end else begin
                wr_addr_d = wr_addr_q + WIN_BITS'(1);
            end
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end

        // Release is applied first, so a bank freed this edge is picked up here.
        if (state_d[wr_bank_d] == FREE) state_d[wr_bank_d] = FILLING;

        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (state_d[i] == FULL) fill_d = fill_d + (BANK_BITS + 1)'(1);
        end
        avail_d = (state_d[rd_bank_d] == FULL);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                state_q[i] <= (i == 0) ? FILLING : FREE;
            end
            wr_bank_q  <= '0;
            wr_addr_q  <= '0;
            rd_bank_q  <= '0;
            act_bank_q <= '0;
            act_vld_q  <= 1'b0;
            avail_q    <= 1'b0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            rd_vld_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
            rd_bank_q  <= rd_bank_d;
            act_bank_q <= act_bank_d;
            act_vld_q  <= act_vld_d;
            avail_q    <= avail_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            rd_vld_q   <= {rd_vld_q[0], rd_fire};
        end
    end

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (SAMPLE_WIDTH),
        .RAM_DEPTH       (NUM_BANKS * WINDOW_SIZE),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_ram (
        .addra  ({wr_bank_q, wr_addr_q}),
        .addrb  ({act_bank_q, rd_addr_in}),
        .dina   (sample_in),
        .dinb   ('0),
        .clka   (clk_in),
        .wea    (wr_fire),
        .web    (1'b0),
        .ena    (wr_fire),
        .enb    (rd_fire),
        .rsta   (1'b0),
        .rstb   (1'b0),
        .regcea (1'b1),
        .regceb (1'b1),
        .douta  (ram_douta_unused),
        .doutb  (ram_doutb)
    );

    // The RAM output register has no async reset; gating keeps rd_data_out at 0 in reset.
    assign rd_data_out       = rd_vld_q[1] ? ram_doutb : '0;
    assign rd_valid_out      = rd_vld_q[1];
    assign win_avail_out     = avail_q;
    assign win_bank_out      = rd_bank_q;
    assign fill_level_out    = fill_q;
    assign overflow_out      = overflow_q;
    assign dropped_count_out = drop_cnt_q;

endmodule

// File: tb/tb_window_ring_buffer.sv
// Self-checking bench for window_ring_buffer: directed scenarios plus random
// traffic, compared against a queue-based model of bank ownership.
module tb_window_ring_buffer;

    localparam int SW = 16;
    localparam int WS = 8;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          win_avail;
    logic [1:0]    win_bank;
    logic          claim;
    logic          rel;
    logic          rd_en;
    logic [2:0]    rd_addr;
    logic [SW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    fill_level;
    logic          overflow;
    logic [15:0]   dropped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    window_ring_buffer #(
        .SAMPLE_WIDTH (SW),
        .WINDOW_SIZE  (WS),
        .NUM_BANKS    (NB)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .sample_in         (sample),
        .sample_valid_in   (sample_valid),
        .win_avail_out     (win_avail),
        .win_bank_out      (win_bank),
        .win_claim_in      (claim),
        .win_release_in    (rel),
        .rd_en_in          (rd_en),
        .rd_addr_in        (rd_addr),
        .rd_data_out       (rd_data),
        .rd_valid_out      (rd_valid),
        .fill_level_out    (fill_level),
        .overflow_out      (overflow),
        .dropped_count_out (dropped)
    );

    // Reference model: sample memory, queue of FULL banks (oldest first),
    // the bank owned by the processor and the bank the writer is filling.
    int m_mem [NB][WS];
    int m_full_q [$];
    int m_active;
    bit m_free [NB];
    int m_wb;
    int m_wa;
    bit m_filling;
    bit m_ovf;
    int m_drop;
    bit m_pv [2];
    int m_pd [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full_q.delete();
        m_active  = -1;
        m_free[0] = 1'b0;
        for (int b = 1; b < NB; b++) m_free[b] = 1'b1;
        m_wb      = 0;
        m_wa      = 0;
        m_filling = 1'b1;
        m_ovf     = 1'b0;
        m_drop    = 0;
        m_pv[0]   = 1'b0;
        m_pv[1]   = 1'b0;
        m_pd[0]   = 0;
        m_pd[1]   = 0;
    endtask

    task automatic model_step(input bit v, input int s, input bit c, input bit r,
                              input bit re, input int ra);
        bit rd_ok;
        int rd_val;
        rd_ok  = re && (m_active >= 0);
        rd_val = 0;
        if (rd_ok) rd_val = m_mem[m_active][ra];

        if (r && m_active >= 0) begin
            m_free[m_active] = 1'b1;
            m_active = -1;
        end else if (c && m_full_q.size() > 0 && m_active < 0) begin
            m_active = m_full_q.pop_front();
        end

        if (v) begin
            if (m_filling) begin
                m_mem[m_wb][m_wa] = s & 32'hFFFF;
                m_wa++;
                if (m_wa == WS) begin
                    m_full_q.push_back(m_wb);
                    m_wa      = 0;
                    m_wb      = (m_wb + 1) % NB;
                    m_filling = 1'b0;
                end
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
        end
        if (!m_filling && m_free[m_wb]) begin
            m_free[m_wb] = 1'b0;
            m_filling    = 1'b1;
        end

        m_pv[1] = m_pv[0];
        m_pd[1] = m_pd[0];
        m_pv[0] = rd_ok;
        m_pd[0] = rd_val;
    endtask

    task automatic compare_all();
        check_val("avail", 32'(win_avail), 32'(m_full_q.size() > 0));
        if (m_full_q.size() > 0) check_val("win_bank", 32'(win_bank), 32'(m_full_q[0]));
        check_val("fill", 32'(fill_level), 32'(m_full_q.size()));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("dropped", 32'(dropped), 32'(m_drop));
        check_val("rd_valid", 32'(rd_valid), 32'(m_pv[1]));
        if (m_pv[1]) check_val("rd_data", 32'(rd_data), 32'(m_pd[1]));
    endtask

    task automatic step(input bit v, input int s, input bit c, input bit r,
                        input bit re, input int ra);
        sample_valid = v;
        sample       = 16'(s);
        claim        = c;
        rel          = r;
        rd_en        = re;
        rd_addr      = 3'(ra);
        model_step(v, s, c, r, re, ra);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic zero_inputs();
        sample_valid = 1'b0;
        sample       = '0;
        claim        = 1'b0;
        rel          = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_avail"}, 32'(win_avail), 32'd0);
        check_val({tag, "_bank"}, 32'(win_bank), 32'd0);
        check_val({tag, "_fill"}, 32'(fill_level), 32'd0);
        check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_val({tag, "_drop"}, 32'(dropped), 32'd0);
        check_val({tag, "_rdv"}, 32'(rd_valid), 32'd0);
        check_val({tag, "_rdd"}, 32'(rd_data), 32'd0);
    endtask

    initial begin
        int nvalid;
        zero_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1'b1;

        // One window written, claimed and read back to back.
        for (int i = 0; i < 8; i++) step(1, i, 0, 0, 0, 0);
        check_val("t1_avail", 32'(win_avail), 32'd1);
        check_val("t1_bank", 32'(win_bank), 32'd0);
        check_val("t1_fill", 32'(fill_level), 32'd1);
        step(0, 0, 1, 0, 0, 0);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 1, i);
            nvalid += int'(rd_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0);
            nvalid += int'(rd_valid);
        end
        check_val("t1_rd_count", 32'(nvalid), 32'd8);

        // Overflow: all banks fill, writer stalls and drops the last 8 samples.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1, i, 0, 0, 0, 0);
            if (i == 15) check_val("t2_fill16", 32'(fill_level), 32'd2);
        end
        check_val("t2_fill", 32'(fill_level), 32'd3);
        check_val("t2_ovf", 32'(overflow), 32'd1);
        check_val("t2_drop", 32'(dropped), 32'd8);

        // Claim bank 0, release it with a read in flight, writer resumes at offset 0.
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 3);
        step(1, 100, 0, 0, 0, 0);
        check_val("t4_rdv", 32'(rd_valid), 32'd1);
        check_val("t4_old_data", 32'(rd_data), 32'd3);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        check_val("t3_bank1_off0", 32'(rd_data), 32'd8);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 1; i < 8; i++) step(1, 100 + i, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check_val("t3_next_bank", 32'(win_bank), 32'd0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        check_val("t3_new_sample", 32'(rd_data), 32'd100);

        // Claim and release together: release wins, bank 1 stays FULL.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, i, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        check_val("t5_avail", 32'(win_avail), 32'd1);
        check_val("t5_bank", 32'(win_bank), 32'd1);
        check_val("t5_fill", 32'(fill_level), 32'd1);
        step(0, 0, 1, 0, 0, 0);
        check_val("t5_fill_after", 32'(fill_level), 32'd0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        check_val("t5_bank1_data", 32'(rd_data), 32'd8);

        // Asynchronous reset pulse between clock edges, mid-write.
        for (int i = 0; i < 3; i++) step(1, 40 + i, 0, 0, 1, i);
        zero_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) step(1, 50 + i, 0, 0, 0, 0);
        check_val("t6_avail", 32'(win_avail), 32'd1);
        check_val("t6_bank", 32'(win_bank), 32'd0);
        check_val("t6_fill", 32'(fill_level), 32'd1);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 7 - i);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 70, int'($urandom_range(0, 65535)),
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 50, int'($urandom_range(0, WS - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
